// File: rtl/scaler_linear_h_mc_pkg.sv
// Shared types and coefficient helpers for the horizontal linear scaler.
// Coefficient 1.0 is 2^(COE_WIDTH-1); positions carry log2(PIXEL_STEP) fraction bits.
package scaler_linear_h_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic int coe_one(input int cw);
    return 1 << (cw - 1);
  endfunction

  function automatic int coe_round(input int cw);
    return 1 << (cw - 2);
  endfunction

  // Right shift that turns the position fraction into the hi-tap coefficient.
  function automatic int coe_shift(input int step_log2, input int cw);
    return step_log2 - cw + 1;
  endfunction

endpackage

// File: rtl/scaler_lerp_ch.sv
// One channel of the 2-tap interpolator: multiply, sum with rounding, clamp.
// Fixed three register stages; the output register only loads on a valid pixel.
module scaler_lerp_ch
  import scaler_linear_h_mc_pkg::*;
#(
  parameter int PIXEL_WIDTH = 12,
  parameter int COE_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] i_lo,
  input  logic [PIXEL_WIDTH-1:0] i_hi,
  input  logic [COE_WIDTH-1:0]   i_c1,
  input  logic                   i_load,
  output logic [PIXEL_WIDTH-1:0] o_y
);

  localparam int PW2  = PIXEL_WIDTH + COE_WIDTH;
  localparam int MAXV = (1 << PIXEL_WIDTH) - 1;

  logic [COE_WIDTH-1:0]   w_c0;
  logic [PW2-1:0]         r_m0, r_m1;
  logic [PW2:0]           r_sum;
  logic [PW2:0]           w_scaled;
  logic [PIXEL_WIDTH-1:0] r_y;

  assign w_c0     = COE_WIDTH'(coe_one(COE_WIDTH)) - i_c1;
  assign w_scaled = r_sum >> (COE_WIDTH - 1);
  assign o_y      = r_y;

  // Operands are unsigned, so only the upper clamp can ever engage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m0  <= '0;
      r_m1  <= '0;
      r_sum <= '0;
      r_y   <= '0;
    end else begin
      r_m0  <= PW2'(w_c0) * PW2'(i_lo);
      r_m1  <= PW2'(i_c1) * PW2'(i_hi);
      r_sum <= (PW2+1)'(r_m0) + (PW2+1)'(r_m1) + (PW2+1)'(coe_round(COE_WIDTH));
      if (i_load) begin
        if (w_scaled > (PW2+1)'(MAXV))
          r_y <= '1;
        else
          r_y <= w_scaled[PIXEL_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/scaler_linear_h_mc.sv
// Multi-channel horizontal linear scaler: position counter and line FSM feeding
// one interpolation pipeline per channel; input is throttled through ready_o.
module scaler_linear_h_mc
  import scaler_linear_h_mc_pkg::*;
#(
  parameter int PIXEL_STEP  = 4096,
  parameter int PIXEL_WIDTH = 12,
  parameter int COE_WIDTH   = 10,
  parameter int CHANNELS    = 3,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [15:0]                     scale_step_h,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  input  logic                            eol_i,
  output logic                            ready_o,
  output logic [CHANNELS*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic [15:0]                     line_len_o,
  output logic                            err_o
);

  localparam int PS_LOG2 = $clog2(PIXEL_STEP);
  localparam int NW      = CNT_WIDTH - PS_LOG2;
  localparam int SHIFT   = coe_shift(PS_LOG2, COE_WIDTH);
  localparam int DW      = CHANNELS * PIXEL_WIDTH;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_p;
  logic [NW-1:0]        r_l;
  logic [DW-1:0]        r_lo, r_hi;
  logic [15:0]          r_step, r_cnt, r_line_len;
  logic                 r_hs_pend, r_vs_pend, r_err, r_rdy_ok;
  logic [2:0]           r_vld, r_hs, r_vs;

  logic [NW-1:0]        w_n;
  logic [PS_LOG2-1:0]   w_f;
  logic [COE_WIDTH-1:0] w_c1;
  logic                 w_at_lo, w_at_hi, w_accept;
  logic                 w_emit, w_edge, w_start, w_shift, w_done, w_abort;
  logic [DW-1:0]        w_tap_lo;

  assign w_n      = r_p[CNT_WIDTH-1:PS_LOG2];
  assign w_f      = r_p[PS_LOG2-1:0];
  assign w_c1     = COE_WIDTH'(w_f >> SHIFT);
  assign w_at_lo  = (({1'b0, w_n} + (NW+1)'(1)) == {1'b0, r_l});
  assign w_at_hi  = (w_n == r_l) && (w_f == '0);
  assign ready_o  = r_rdy_ok && ((r_state == ST_IDLE) || ((r_state == ST_RUN) && !w_at_lo));
  assign w_accept = de_i && ready_o;
  assign w_abort  = w_start && (r_state == ST_RUN);
  assign w_tap_lo = w_edge ? r_hi : r_lo;

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_edge      = 1'b0;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && hs_i) begin
          w_start     = 1'b1;
          w_state_nxt = eol_i ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_at_lo) begin
          w_emit = 1'b1;
        end else if (w_accept) begin
          if (hs_i) begin
            w_start     = 1'b1;
            w_state_nxt = eol_i ? ST_FLUSH : ST_RUN;
          end else begin
            w_shift = 1'b1;
            if (eol_i) w_state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Past the last pair, a position landing exactly on the last pixel replicates it.
        if (w_at_lo) begin
          w_emit = 1'b1;
        end else if (w_at_hi) begin
          w_emit = 1'b1;
          w_edge = 1'b1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_p        <= '0;
      r_l        <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_step     <= 16'(PIXEL_STEP);
      r_cnt      <= '0;
      r_line_len <= '0;
      r_hs_pend  <= 1'b0;
      r_vs_pend  <= 1'b0;
      r_err      <= 1'b0;
      r_rdy_ok   <= 1'b0;
      r_vld      <= '0;
      r_hs       <= '0;
      r_vs       <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_ok <= 1'b1;
      r_err    <= w_abort;
      r_vld    <= {r_vld[1:0], w_emit};
      r_hs     <= {r_hs[1:0], w_emit && r_hs_pend};
      r_vs     <= {r_vs[1:0], w_emit && r_vs_pend};
      if (w_start) begin
        r_p       <= '0;
        r_l       <= '0;
        r_lo      <= di_i;
        r_hi      <= di_i;
        r_cnt     <= '0;
        r_hs_pend <= 1'b1;
        if (vs_i) begin
          r_vs_pend <= 1'b1;
          if (scale_step_h == '0) begin
            r_step <= 16'(PIXEL_STEP);
            r_err  <= 1'b1;
          end else begin
            r_step <= scale_step_h;
          end
        end
      end
      if (w_shift) begin
        r_lo <= r_hi;
        r_hi <= di_i;
        r_l  <= r_l + NW'(1);
      end
      if (w_emit) begin
        r_p       <= r_p + CNT_WIDTH'(r_step);
        r_cnt     <= r_cnt + 16'd1;
        r_hs_pend <= 1'b0;
        r_vs_pend <= 1'b0;
      end
      if (w_done) r_line_len <= r_cnt;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    scaler_lerp_ch #(
      .PIXEL_WIDTH(PIXEL_WIDTH),
      .COE_WIDTH  (COE_WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_lo  (w_tap_lo[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .i_hi  (r_hi[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .i_c1  (w_c1),
      .i_load(r_vld[1]),
      .o_y   (do_o[g*PIXEL_WIDTH +: PIXEL_WIDTH])
    );
  end

  assign de_o       = r_vld[2];
  assign hs_o       = r_hs[2];
  assign vs_o       = r_vs[2];
  assign line_len_o = r_line_len;
  assign err_o      = r_err;

endmodule

// File: tb/tb_scaler_linear_h_mc.sv
// Bench for scaler_linear_h_mc: directed and random lines scored against an
// arithmetic model of the resampling rule (position k*S, 2-tap lerp, clamp).
module tb_scaler_linear_h_mc;

  localparam int PS      = 4096;
  localparam int PW      = 12;
  localparam int CW      = 10;
  localparam int CH      = 3;
  localparam int DW      = CH * PW;
  localparam int SHIFT   = 12 - CW + 1;
  localparam int COE_ONE = 1 << (CW - 1);
  localparam int ROUND   = 1 << (CW - 2);
  localparam int MAXV    = (1 << PW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    bit            hs;
    bit            vs;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   scale_step_h = '0;
  logic [DW-1:0] di_i = '0;
  logic          de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, eol_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] do_o;
  logic          de_o, hs_o, vs_o, err_o;
  logic [15:0]   line_len_o;

  exp_t          expQ[$];
  logic [DW-1:0] pix[$];
  int            checks = 0, errors = 0;
  int            errSeen = 0, expErr = 0;
  int            curStep = PS, lastLen = 0;
  bit            vsPend = 1'b0;

  always #5 clk = ~clk;

  scaler_linear_h_mc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scale_step_h(scale_step_h),
    .di_i        (di_i),
    .de_i        (de_i),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
    .eol_i       (eol_i),
    .ready_o     (ready_o),
    .do_o        (do_o),
    .de_o        (de_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .line_len_o  (line_len_o),
    .err_o       (err_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every output pixel must match the front of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (err_o) errSeen++;
    if (de_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_de", 64'(de_o), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("do", 64'(do_o), 64'(e.d));
        checkOutput("hs", 64'(hs_o), 64'(e.hs));
        checkOutput("vs", 64'(vs_o), 64'(e.vs));
      end
    end
  end

  function automatic int lerpRef(input int a, input int b, input int f);
    int c1, c0, y;
    c1 = f >> SHIFT;
    c0 = COE_ONE - c1;
    y  = (c0 * a + c1 * b + ROUND) >> (CW - 1);
    if (y > MAXV) y = MAXV;
    if (y < 0) y = 0;
    return y;
  endfunction

  // Outputs are every k with k*S <= (N-1)*PS for a finished line, or
  // k*S < (M-1)*PS for a line cut off after M pixels.
  task automatic modelLine(input int nFed, input bit full, output int cnt);
    cnt = 0;
    for (int k = 0; k < 70000; k++) begin
      longint p, lim;
      int n, f, a, b;
      exp_t e;
      p   = longint'(k) * longint'(curStep);
      lim = longint'(nFed - 1) * PS;
      if (full ? (p > lim) : (p >= lim)) break;
      n = int'(p / PS);
      f = int'(p % PS);
      e.d = '0;
      for (int c = 0; c < CH; c++) begin
        a = int'(pix[n][c*PW +: PW]);
        b = (n + 1 < nFed) ? int'(pix[n+1][c*PW +: PW]) : a;
        e.d[c*PW +: PW] = PW'(lerpRef(a, b, f));
      end
      e.hs   = (k == 0);
      e.vs   = vsPend;
      vsPend = 1'b0;
      expQ.push_back(e);
      cnt++;
    end
  endtask

  task automatic sendPixel(input logic [DW-1:0] d, input bit hs, input bit vs, input bit eol, input bit gap);
    int guard;
    if (gap) begin
      de_i = 1'b0;
      @(posedge clk); #1;
    end
    di_i = d; hs_i = hs; vs_i = vs; eol_i = eol; de_i = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      guard++;
      if (guard > 200) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; eol_i = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!ready_o && guard < 500);
    if (!ready_o) checkOutput("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input bit newFrame, input int stepVal, input int nPix,
                               input bit full, input bit gaps);
    int cnt;
    scale_step_h = 16'(stepVal);
    if (newFrame) begin
      curStep = (stepVal == 0) ? PS : stepVal;
      vsPend  = 1'b1;
      if (stepVal == 0) expErr++;
    end
    modelLine(nPix, full, cnt);
    for (int i = 0; i < nPix; i++) begin
      sendPixel(pix[i], i == 0, newFrame && (i == 0), full && (i == nPix - 1),
                gaps && ($urandom_range(0, 3) == 0));
      if (i == 0) checkOutput("len_held", 64'(line_len_o), 64'(lastLen));
    end
    if (full) begin
      waitIdle();
      checkOutput("line_len", 64'(line_len_o), 64'(cnt));
      lastLen = cnt;
      repeat (6) @(negedge clk);
      checkOutput("drained", 64'(expQ.size()), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic setLine(input int vals[$]);
    logic [DW-1:0] w;
    pix.delete();
    foreach (vals[i]) begin
      for (int c = 0; c < CH; c++) w[c*PW +: PW] = PW'(vals[i]);
      pix.push_back(w);
    end
  endtask

  task automatic fillRandom(input int n);
    logic [DW-1:0] w;
    pix.delete();
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) w[c*PW +: PW] = PW'($urandom_range(0, MAXV));
      pix.push_back(w);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int vals[$];
    logic [DW-1:0] w;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_de", 64'(de_o), 64'd0);
    checkOutput("rst_hs", 64'(hs_o), 64'd0);
    checkOutput("rst_vs", 64'(vs_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
    checkOutput("rst_do", 64'(do_o), 64'd0);
    checkOutput("rst_len", 64'(line_len_o), 64'd0);
    checkOutput("rst_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_pre", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    checkOutput("ready_post", 64'(ready_o), 64'd1);

    vals = '{100, 200, 300, 400};
    setLine(vals);
    applyStimulus(1, 4096, 4, 1, 0);

    vals = '{0, 1000, 2000};
    setLine(vals);
    applyStimulus(1, 2048, 3, 1, 0);

    vals = '{10, 20, 30, 40, 50, 60};
    setLine(vals);
    applyStimulus(1, 8192, 6, 1, 1);

    vals = '{0, 1200, 2400, 3600};
    setLine(vals);
    for (int i = 0; i < 4; i++) begin
      w = pix[i];
      w[PW +: PW]   = PW'($urandom_range(0, MAXV));
      w[2*PW +: PW] = PW'($urandom_range(0, MAXV));
      pix[i] = w;
    end
    applyStimulus(1, 6144, 4, 1, 0);

    vals = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    setLine(vals);
    applyStimulus(1, 3000, 8, 1, 0);
    applyStimulus(0, 500, 8, 1, 1);

    fillRandom(5);
    applyStimulus(1, 0, 5, 1, 0);

    vals = '{7};
    setLine(vals);
    applyStimulus(0, 0, 1, 1, 0);

    fillRandom(5);
    applyStimulus(1, 2048, 3, 0, 0);
    expErr++;
    fillRandom(4);
    applyStimulus(0, 2048, 4, 1, 0);

    for (int ln = 0; ln < 25; ln++) begin
      if ($urandom_range(0, 1) == 1) sendPixel(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      fillRandom($urandom_range(1, 12));
      applyStimulus(ln % 5 == 0, $urandom_range(1024, 12000), pix.size(), 1, $urandom_range(0, 1) == 1);
    end

    fillRandom(6);
    applyStimulus(1, 2500, 4, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expQ.delete();
    vsPend  = 1'b0;
    lastLen = 0;
    @(negedge clk);
    checkOutput("midrst_de", 64'(de_o), 64'd0);
    checkOutput("midrst_ready", 64'(ready_o), 64'd0);
    checkOutput("midrst_len", 64'(line_len_o), 64'd0);
    @(posedge clk); #1;
    checkOutput("midrst_ready_post", 64'(ready_o), 64'd1);
    fillRandom(7);
    applyStimulus(1, 3500, 7, 1, 1);

    checkOutput("err_count", 64'(errSeen), 64'(expErr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
